// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one block-wide memory port between two cache controllers.
// Each transaction is latched on grant, held during BUSY and answered with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_DATA_WIDTH = 512,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        p0_req_enable,
  input  logic                        p0_req_rw,
  input  logic [WORD_SIZE-1:0]        p0_req_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] p0_req_dataout,
  output logic [BLOCK_DATA_WIDTH-1:0] p0_req_datain,
  output logic                        p0_req_ready,
  output logic                        p0_req_error,
  input  logic                        p1_req_enable,
  input  logic                        p1_req_rw,
  input  logic [WORD_SIZE-1:0]        p1_req_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] p1_req_dataout,
  output logic [BLOCK_DATA_WIDTH-1:0] p1_req_datain,
  output logic                        p1_req_ready,
  output logic                        p1_req_error,
  output logic                        mem_req_enable,
  output logic                        mem_req_rw,
  output logic [WORD_SIZE-1:0]        mem_req_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
  input  logic                        mem_req_ready
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort fires on the edge that ends the TIMEOUT_CYCLES-th BUSY cycle, i.e. when the count is T-1.
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic [CW-1:0] tcnt;
  logic          pick;

  always_comb begin
    pick = 1'b0;
    if (p0_req_enable && p1_req_enable) pick = ~last_grant;
    else if (p1_req_enable)             pick = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      grant           <= 1'b0;
      last_grant      <= 1'b1;
      tcnt            <= '0;
      mem_req_enable  <= 1'b0;
      mem_req_rw      <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_dataout <= '0;
      p0_req_datain   <= '0;
      p1_req_datain   <= '0;
      p0_req_ready    <= 1'b0;
      p1_req_ready    <= 1'b0;
      p0_req_error    <= 1'b0;
      p1_req_error    <= 1'b0;
    end else begin
      p0_req_ready <= 1'b0;
      p1_req_ready <= 1'b0;
      p0_req_error <= 1'b0;
      p1_req_error <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req_enable || p1_req_enable) begin
            grant           <= pick;
            last_grant      <= pick;
            mem_req_rw      <= pick ? p1_req_rw      : p0_req_rw;
            mem_req_addr    <= pick ? p1_req_addr    : p0_req_addr;
            mem_req_dataout <= pick ? p1_req_dataout : p0_req_dataout;
            mem_req_enable  <= 1'b1;
            tcnt            <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (mem_req_ready) begin
            mem_req_enable <= 1'b0;
            if (grant) begin
              p1_req_ready <= 1'b1;
              if (!mem_req_rw) p1_req_datain <= mem_req_datain;
            end else begin
              p0_req_ready <= 1'b1;
              if (!mem_req_rw) p0_req_datain <= mem_req_datain;
            end
            state <= RESPOND;
          end else if ((TIMEOUT_CYCLES != 0) && (tcnt == TLIM)) begin
            mem_req_enable <= 1'b0;
            if (grant) begin
              p1_req_ready <= 1'b1;
              p1_req_error <= 1'b1;
            end else begin
              p0_req_ready <= 1'b1;
              p0_req_error <= 1'b1;
            end
            state <= RESPOND;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: tests push expected memory requests and port responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

  logic         clk;
  logic         rst_n;
  logic         p0_req_enable, p0_req_rw, p1_req_enable, p1_req_rw;
  logic [31:0]  p0_req_addr, p1_req_addr;
  logic [511:0] p0_req_dataout, p1_req_dataout, p0_req_datain, p1_req_datain;
  logic         p0_req_ready, p0_req_error, p1_req_ready, p1_req_error;
  logic         mem_req_enable, mem_req_rw, mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic [511:0] mem_req_dataout, mem_req_datain;

  mem_port_arbiter #(.WORD_SIZE(32), .BLOCK_DATA_WIDTH(512), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_enable(p0_req_enable), .p0_req_rw(p0_req_rw), .p0_req_addr(p0_req_addr),
    .p0_req_dataout(p0_req_dataout), .p0_req_datain(p0_req_datain),
    .p0_req_ready(p0_req_ready), .p0_req_error(p0_req_error),
    .p1_req_enable(p1_req_enable), .p1_req_rw(p1_req_rw), .p1_req_addr(p1_req_addr),
    .p1_req_dataout(p1_req_dataout), .p1_req_datain(p1_req_datain),
    .p1_req_ready(p1_req_ready), .p1_req_error(p1_req_error),
    .mem_req_enable(mem_req_enable), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_dataout(mem_req_dataout), .mem_req_datain(mem_req_datain),
    .mem_req_ready(mem_req_ready)
  );

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [511:0] dout;
    int           len;
    int           gap;
  } mexp_t;

  typedef struct {
    int           port;
    logic         err;
    logic [511:0] din;
  } rexp_t;

  mexp_t        mq[$];
  rexp_t        rq[$];
  mexp_t        cur;
  logic [511:0] shadow [2];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           mem_lat = 3;
  int           seen = 0;
  logic [31:0]  mem_base = 32'h0;
  logic         stray = 1'b0;
  logic         prev_en = 1'b0;
  logic         prev_rdy = 1'b0;
  logic         have_cur = 1'b0;
  int           en_len = 0;
  int           last_rdy_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] blk(input logic [31:0] b);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = b + 32'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  // Memory model: answers after mem_lat cycles of enable (0 = never); stray injects a bogus ready.
  always @(negedge clk) begin
    mem_req_datain = blk(mem_base);
    if (mem_req_enable) begin
      seen = seen + 1;
      mem_req_ready = ((mem_lat != 0) && (seen == mem_lat)) || stray;
    end else begin
      seen = 0;
      mem_req_ready = stray;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (mem_req_enable && !prev_en) begin
      en_len = 1;
      if (mq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_req got addr %h exp none", mem_req_addr);
        have_cur = 1'b0;
      end else begin
        cur = mq.pop_front();
        have_cur = 1'b1;
        chk("mem_rw", 512'(mem_req_rw), 512'(cur.rw));
        chk("mem_addr", 512'(mem_req_addr), 512'(cur.addr));
        chk("mem_dataout", mem_req_dataout, cur.dout);
        if (cur.gap >= 0) chk("issue_gap", 512'(cyc - last_rdy_cyc), 512'(cur.gap));
      end
    end else if (mem_req_enable) begin
      en_len = en_len + 1;
      if (have_cur) chk("addr_stable", 512'(mem_req_addr), 512'(cur.addr));
    end else if (prev_en && have_cur && cur.len != 0) begin
      chk("enable_len", 512'(en_len), 512'(cur.len));
    end
    prev_en = mem_req_enable;

    if (p0_req_ready || p1_req_ready) begin
      chk("ready_pulse", 512'(prev_rdy), 512'(0));
      last_rdy_cyc = cyc;
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready got p0 %b p1 %b exp none", p0_req_ready, p1_req_ready);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        chk("resp_port", {510'd0, p1_req_ready, p0_req_ready}, (r.port == 1) ? 512'd2 : 512'd1);
        chk("resp_error", 512'(r.port == 1 ? p1_req_error : p0_req_error), 512'(r.err));
        chk("resp_datain", (r.port == 1) ? p1_req_datain : p0_req_datain, r.din);
      end
    end
    prev_rdy = p0_req_ready || p1_req_ready;
  end

  task automatic issue(input int port, input logic rw, input logic [31:0] addr, input logic [511:0] d);
    if (port == 0) begin
      p0_req_enable = 1'b1; p0_req_rw = rw; p0_req_addr = addr; p0_req_dataout = d;
    end else begin
      p1_req_enable = 1'b1; p1_req_rw = rw; p1_req_addr = addr; p1_req_dataout = d;
    end
  endtask

  task automatic expect_txn(input int port, input logic rw, input logic [31:0] addr,
                            input logic [511:0] d, input int len, input int gap,
                            input logic err);
    mq.push_back('{rw: rw, addr: addr, dout: d, len: len, gap: gap});
    if (!rw && !err) shadow[port] = blk(mem_base);
    rq.push_back('{port: port, err: err, din: shadow[port]});
  endtask

  // Requester side: drop enable during RESPOND, bounded wait for all responses.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((rq.size() != 0 || p0_req_enable || p1_req_enable) && n < budget) begin
      @(negedge clk);
      if (p0_req_ready) p0_req_enable = 1'b0;
      if (p1_req_ready) p1_req_enable = 1'b0;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_done got pending %0d exp 0", rq.size());
      p0_req_enable = 1'b0; p1_req_enable = 1'b0;
      rq.delete(); mq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(input int budget);
    int n;
    n = 0;
    while (!mem_req_enable && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_enable) begin
      checks++; errors++;
      $display("FAIL wait_enable got 0 exp 1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    p0_req_enable = 1'b0; p0_req_rw = 1'b0; p0_req_addr = '0; p0_req_dataout = '0;
    p1_req_enable = 1'b0; p1_req_rw = 1'b0; p1_req_addr = '0; p1_req_dataout = '0;
    shadow[0] = '0; shadow[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_enable", 512'(mem_req_enable), 512'(0));
    chk("rst_mem_rw", 512'(mem_req_rw), 512'(0));
    chk("rst_mem_addr", 512'(mem_req_addr), 512'(0));
    chk("rst_mem_dataout", mem_req_dataout, 512'(0));
    chk("rst_ready", {510'd0, p1_req_ready, p0_req_ready}, 512'(0));
    chk("rst_error", {510'd0, p1_req_error, p0_req_error}, 512'(0));
    chk("rst_p0_datain", p0_req_datain, 512'(0));
    chk("rst_p1_datain", p1_req_datain, 512'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous pair right after reset: p0 wins, p1 issued 2 cycles after p0's ready pulse
    mem_lat = 3; mem_base = 32'h5A5A_0000;
    expect_txn(0, 1'b1, 32'h100, blk(32'h1111_0000), 3, -1, 1'b0);
    expect_txn(1, 1'b0, 32'h200, blk(32'h2222_0000), 3, 2, 1'b0);
    issue(0, 1'b1, 32'h100, blk(32'h1111_0000));
    issue(1, 1'b0, 32'h200, blk(32'h2222_0000));
    wait_done(40);

    // Single p0 read
    mem_base = 32'hDEAD_BEEF;
    expect_txn(0, 1'b0, 32'h0000_0A40, blk(32'h0), 3, -1, 1'b0);
    issue(0, 1'b0, 32'h0000_0A40, blk(32'h0));
    wait_done(30);

    // Second pair: p0 was last granted, so p1 goes first
    mem_base = 32'h6B6B_0000;
    expect_txn(1, 1'b1, 32'h280, blk(32'h4444_0000), 3, -1, 1'b0);
    expect_txn(0, 1'b0, 32'h180, blk(32'h3333_0000), 3, 2, 1'b0);
    issue(0, 1'b0, 32'h180, blk(32'h3333_0000));
    issue(1, 1'b1, 32'h280, blk(32'h4444_0000));
    wait_done(40);

    // p1 write; requester inputs change mid-BUSY and must not leak through
    expect_txn(1, 1'b1, 32'h300, blk(32'hCAFE_BABE), 3, -1, 1'b0);
    issue(1, 1'b1, 32'h300, blk(32'hCAFE_BABE));
    wait_enable(10);
    p1_req_addr = 32'hFFFF_FFFF; p1_req_dataout = '1;
    wait_done(30);

    // Timeout: memory silent, enable high exactly 8 cycles, error flagged
    mem_lat = 0;
    expect_txn(0, 1'b0, 32'h400, blk(32'h0), 8, -1, 1'b1);
    issue(0, 1'b0, 32'h400, blk(32'h0));
    wait_done(60);

    // Ready on the exact timeout edge: ready wins
    mem_lat = 8; mem_base = 32'h7777_0000;
    expect_txn(0, 1'b0, 32'h500, blk(32'h0), 8, -1, 1'b0);
    issue(0, 1'b0, 32'h500, blk(32'h0));
    wait_done(60);

    // Reset two cycles into BUSY: no ready pulse, later stray ready ignored
    mem_lat = 5;
    mq.push_back('{rw: 1'b0, addr: 32'h600, dout: blk(32'h0), len: 0, gap: -1});
    issue(0, 1'b0, 32'h600, blk(32'h0));
    wait_enable(10);
    @(negedge clk);
    rst_n = 1'b0; p0_req_enable = 1'b0;
    @(negedge clk);
    chk("midrst_enable", 512'(mem_req_enable), 512'(0));
    chk("midrst_ready", {510'd0, p1_req_ready, p0_req_ready}, 512'(0));
    chk("midrst_p0_datain", p0_req_datain, 512'(0));
    shadow[0] = '0; shadow[1] = '0;
    @(posedge clk); #1 rst_n = 1'b1; stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_enable", 512'(mem_req_enable), 512'(0));
    chk("stray_p0_datain", p0_req_datain, 512'(0));
    @(posedge clk); #1;

    mem_lat = 3; mem_base = 32'h9999_0000;
    expect_txn(1, 1'b0, 32'h700, blk(32'h0), 3, -1, 1'b0);
    issue(1, 1'b0, 32'h700, blk(32'h0));
    wait_done(30);

    chk("queues_drained", 512'(mq.size() + rq.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
